dmem_lsu: RTL and testbench

Parametrised data-memory load/store unit for the pipelined core; replaces the fixed 32-word, word-only data memory. Accepts one byte-addressed request at a time over a valid/ready handshake and performs RISC-V byte, half and word accesses with byte-lane writes and sign/zero-extended reads. Read latency is configurable, and responses are held until the pipeline accepts them. Sits between the execute stage (address/data) and the writeback stage (load data).

---
 rtl/dmem_lsu_if.sv | 24 ++
 rtl/dmem_lsu.sv | 171 +++++++++++++++++
 tb/tb_dmem_lsu.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/dmem_lsu_if.sv
// Request/response bundle between the pipeline and the data-memory load/store unit.
// The master is the execute/writeback side; the slave is dmem_lsu.
interface dmem_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_lsu.sv
// Byte-addressed data memory with RISC-V B/H/W accesses and configurable read latency.
// Define DMEM_MISALIGN_TRAP_EN to reject misaligned H/HU/W accesses instead of aligning them.
module dmem_lsu #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned LAT   = 1
) (
  input logic       clk,
  input logic       rst,
  dmem_lsu_if.slave bus_io
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CW-1:0] CntLast = CW'(LAT - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           we_q;
  logic [2:0]     funct3_q;
  logic [AW+1:0]  addr_q;
  logic [31:0]    wdata_q;
  logic [31:0]    rdata_q, rdata_d;
  logic           err_q, err_d;
  logic           accept;
  logic           access;

  logic [31:0]    mem_q [DEPTH];

  logic           legal;
  logic           misalign;
  logic           bad;
  logic [1:0]     off;
  logic [AW-1:0]  idx;
  logic [3:0]     be;
  logic [31:0]    wlanes;
  logic [31:0]    rword;
  logic [31:0]    rshift;
  logic [31:0]    load_val;

  // Upper address bits only select an alias of the same word.
  logic unused_addr;
  assign unused_addr = ^bus_io.req_addr[31:AW+2];

  // Decode of the latched request.
  always_comb begin
    legal = 1'b0;
    case (funct3_q)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = ~we_q;
      default:                legal = 1'b0;
    endcase

`ifdef DMEM_MISALIGN_TRAP_EN
    misalign = ((funct3_q[1:0] == 2'b01) && addr_q[0]) ||
               ((funct3_q == 3'b010) && (addr_q[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif
    bad = ~legal | misalign;

    // Misaligned low bits are dropped so H/W stay within their natural lanes.
    off = addr_q[1:0];
    if (funct3_q[1:0] == 2'b01) off[0] = 1'b0;
    if (funct3_q[1:0] == 2'b10) off = 2'b00;

    idx = addr_q[2 +: AW];

    case (funct3_q[1:0])
      2'b00: begin
        be     = 4'b0001 << off;
        wlanes = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be     = 4'b0011 << off;
        wlanes = {2{wdata_q[15:0]}};
      end
      default: begin
        be     = 4'b1111;
        wlanes = wdata_q;
      end
    endcase

    rword  = mem_q[idx];
    rshift = rword >> {off, 3'b000};
    case (funct3_q)
      3'b000:  load_val = {{24{rshift[7]}}, rshift[7:0]};
      3'b001:  load_val = {{16{rshift[15]}}, rshift[15:0]};
      3'b100:  load_val = {24'h0, rshift[7:0]};
      3'b101:  load_val = {16'h0, rshift[15:0]};
      default: load_val = rshift;
    endcase
  end

  // Next-state and response capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    accept  = 1'b0;
    access  = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus_io.req_valid) begin
          accept  = 1'b1;
          cnt_d   = '0;
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q == CntLast) begin
          access  = 1'b1;
          state_d = StResp;
          err_d   = bad;
          rdata_d = (bad || we_q) ? 32'h0 : load_val;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StResp: begin
        if (bus_io.rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus_io.req_ready = (state_q == StIdle) && !rst;
  assign bus_io.rsp_valid = (state_q == StResp);
  assign bus_io.rsp_rdata = rdata_q;
  assign bus_io.rsp_err   = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= 32'h0;
    end else if (accept) begin
      we_q     <= bus_io.req_we;
      funct3_q <= bus_io.req_funct3;
      addr_q   <= bus_io.req_addr[AW+1:0];
      wdata_q  <= bus_io.req_wdata;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (access && we_q && !bad) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[idx][8*b +: 8] <= wlanes[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: one LAT=1 and one LAT=3 instance, both DEPTH=32.
module tb_dmem_lsu;

  logic clk = 1'b0;
  logic rst1 = 1'b1;
  logic rst3 = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  dmem_lsu_if if1 ();
  dmem_lsu_if if3 ();

  dmem_lsu #(.DEPTH(32), .LAT(1)) u1 (.clk(clk), .rst(rst1), .bus_io(if1));
  dmem_lsu #(.DEPTH(32), .LAT(3)) u3 (.clk(clk), .rst(rst3), .bus_io(if3));

  localparam logic [2:0] FB = 3'b000, FH = 3'b001, FW = 3'b010, FBU = 3'b100, FHU = 3'b101;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drv(input int sel, input logic v, input logic we, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd, input logic rr);
    if (sel == 1) begin
      if1.req_valid = v; if1.req_we = we; if1.req_funct3 = f3;
      if1.req_addr = a; if1.req_wdata = wd; if1.rsp_ready = rr;
    end else begin
      if3.req_valid = v; if3.req_we = we; if3.req_funct3 = f3;
      if3.req_addr = a; if3.req_wdata = wd; if3.rsp_ready = rr;
    end
  endtask

  function automatic logic rdy(input int sel);
    return (sel == 1) ? if1.req_ready : if3.req_ready;
  endfunction

  function automatic logic vld(input int sel);
    return (sel == 1) ? if1.rsp_valid : if3.rsp_valid;
  endfunction

  // One request with rsp_ready held high; lat counts edges from accept to rsp_valid.
  task automatic xact(input int sel, input logic we, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er, output int lat);
    int n;
    @(negedge clk);
    drv(sel, 1'b1, we, f3, a, wd, 1'b1);
    n = 0;
    while (!rdy(sel) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", 32'(n < 20), 32'd1);
    @(posedge clk);
    @(negedge clk);
    drv(sel, 1'b0, 1'b0, FW, 32'h0, 32'h0, 1'b1);
    lat = 0;
    while (!vld(sel) && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rd = (sel == 1) ? if1.rsp_rdata : if3.rsp_rdata;
    er = (sel == 1) ? if1.rsp_err : if3.rsp_err;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [31:0] held;

    drv(1, 1'b0, 1'b0, FW, 32'h0, 32'h0, 1'b0);
    drv(3, 1'b0, 1'b0, FW, 32'h0, 32'h0, 1'b0);

    @(negedge clk);
    chk("rst_req_ready", 32'(if1.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(if1.rsp_valid), 32'd0);
    chk("rst_rsp_rdata", if1.rsp_rdata, 32'h0);
    chk("rst_rsp_err", 32'(if1.rsp_err), 32'd0);
    rst1 = 1'b0;
    rst3 = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", 32'(if1.req_ready), 32'd1);
    chk("post_rst_req_ready3", 32'(if3.req_ready), 32'd1);

    // LAT=1 word store and load
    xact(1, 1'b1, FW, 32'h10, 32'hDEADBEEF, rd, er, lat);
    chk("sw_lat", 32'(lat), 32'd1);
    chk("sw_rdata", rd, 32'h0);
    chk("sw_err", 32'(er), 32'd0);
    xact(1, 1'b0, FW, 32'h10, 32'h0, rd, er, lat);
    chk("lw_lat", 32'(lat), 32'd1);
    chk("lw_rdata", rd, 32'hDEADBEEF);
    chk("lw_err", 32'(er), 32'd0);

    // Byte store into a cleared word, signed/unsigned byte loads
    xact(1, 1'b1, FW, 32'h10, 32'h0, rd, er, lat);
    xact(1, 1'b1, FB, 32'h13, 32'hFFFFFF80, rd, er, lat);
    xact(1, 1'b0, FB, 32'h13, 32'h0, rd, er, lat);
    chk("lb_13", rd, 32'hFFFFFF80);
    xact(1, 1'b0, FBU, 32'h13, 32'h0, rd, er, lat);
    chk("lbu_13", rd, 32'h00000080);
    xact(1, 1'b0, FW, 32'h10, 32'h0, rd, er, lat);
    chk("lw_after_sb", rd, 32'h80000000);

    // Half-word lanes
    xact(1, 1'b1, FW, 32'h20, 32'h11223344, rd, er, lat);
    xact(1, 1'b1, FH, 32'h22, 32'h5555ABCD, rd, er, lat);
    xact(1, 1'b0, FH, 32'h22, 32'h0, rd, er, lat);
    chk("lh_22", rd, 32'hFFFFABCD);
    chk("lh_22_err", 32'(er), 32'd0);
    xact(1, 1'b0, FHU, 32'h22, 32'h0, rd, er, lat);
    chk("lhu_22", rd, 32'h0000ABCD);
    xact(1, 1'b0, FH, 32'h21, 32'h0, rd, er, lat);
`ifdef DMEM_MISALIGN_TRAP_EN
    chk("lh_21_rdata", rd, 32'h0);
    chk("lh_21_err", 32'(er), 32'd1);
    chk("lh_21_lat", 32'(lat), 32'd1);
`else
    chk("lh_21_rdata", rd, 32'h00003344);
    chk("lh_21_err", 32'(er), 32'd0);
`endif
    xact(1, 1'b0, FW, 32'h21, 32'h0, rd, er, lat);
`ifdef DMEM_MISALIGN_TRAP_EN
    chk("lw_21_rdata", rd, 32'h0);
    chk("lw_21_err", 32'(er), 32'd1);
`else
    chk("lw_21_rdata", rd, 32'hABCD3344);
    chk("lw_21_err", 32'(er), 32'd0);
`endif

    // Illegal encodings leave memory untouched
    xact(1, 1'b1, 3'b011, 32'h10, 32'hFFFFFFFF, rd, er, lat);
    chk("ill_011_err", 32'(er), 32'd1);
    chk("ill_011_rdata", rd, 32'h0);
    xact(1, 1'b1, FBU, 32'h10, 32'hFFFFFFFF, rd, er, lat);
    chk("ill_sbu_err", 32'(er), 32'd1);
    xact(1, 1'b0, 3'b111, 32'h10, 32'h0, rd, er, lat);
    chk("ill_111_load_err", 32'(er), 32'd1);
    chk("ill_111_load_rdata", rd, 32'h0);
    xact(1, 1'b0, FW, 32'h10, 32'h0, rd, er, lat);
    chk("ill_readback", rd, 32'h80000000);
    chk("ill_readback_err", 32'(er), 32'd0);

    // Address wrap at DEPTH*4 = 0x80
    xact(1, 1'b1, FW, 32'h84, 32'h12345678, rd, er, lat);
    xact(1, 1'b0, FW, 32'h04, 32'h0, rd, er, lat);
    chk("wrap_rdata", rd, 32'h12345678);

    // LAT=3 instance
    xact(3, 1'b1, FW, 32'h04, 32'hCAFEF00D, rd, er, lat);
    chk("l3_sw_lat", 32'(lat), 32'd3);
    xact(3, 1'b0, FW, 32'h04, 32'h0, rd, er, lat);
    chk("l3_lw_lat", 32'(lat), 32'd3);
    chk("l3_lw_rdata", rd, 32'hCAFEF00D);

    // Response held while rsp_ready is low; a pending request must wait
    @(negedge clk);
    drv(3, 1'b1, 1'b0, FW, 32'h04, 32'h0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drv(3, 1'b1, 1'b1, FW, 32'h04, 32'h99999999, 1'b0);
    lat = 0;
    while (!if3.rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("hold_lat", 32'(lat), 32'd3);
    held = if3.rsp_rdata;
    chk("hold_rdata0", held, 32'hCAFEF00D);
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", 32'(if3.rsp_valid), 32'd1);
      chk("hold_rdata", if3.rsp_rdata, 32'hCAFEF00D);
      chk("hold_req_ready", 32'(if3.req_ready), 32'd0);
      @(negedge clk);
    end
    drv(3, 1'b0, 1'b0, FW, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    chk("hold_taken_valid", 32'(if3.rsp_valid), 32'd0);
    chk("hold_taken_ready", 32'(if3.req_ready), 32'd1);
    xact(3, 1'b0, FW, 32'h04, 32'h0, rd, er, lat);
    chk("hold_no_store", rd, 32'hCAFEF00D);

    // Reset in WAIT aborts the store
    @(negedge clk);
    drv(3, 1'b1, 1'b1, FW, 32'h04, 32'hBAD0BAD0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drv(3, 1'b0, 1'b0, FW, 32'h0, 32'h0, 1'b1);
    rst3 = 1'b1;
    @(negedge clk);
    chk("abort_valid", 32'(if3.rsp_valid), 32'd0);
    chk("abort_ready_in_rst", 32'(if3.req_ready), 32'd0);
    rst3 = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_valid_after", 32'(if3.rsp_valid), 32'd0);
    xact(3, 1'b0, FW, 32'h04, 32'h0, rd, er, lat);
    chk("abort_readback", rd, 32'hCAFEF00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
